highlight_mode_sched: RTL



---
 rtl/highlight_mode_sched_pkg.sv | 57 +++++
 rtl/highlight_mode_sched_if.sv | 27 ++
 rtl/highlight_mode_sched_edge_pulse.sv | 24 ++
 rtl/highlight_mode_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/highlight_mode_sched_pkg.sv
// Shared definitions for the colour-highlight scheduler and the highlight datapath:
// mode codes, threshold-select codes, default thresholds and small helpers.
package highlight_mode_sched_pkg;

  localparam int HMS_THR_W = 25;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RED   = 2'b01;
  localparam mode_t MODE_GREEN = 2'b00;
  localparam mode_t MODE_BLUE  = 2'b10;
  localparam mode_t MODE_PASS  = 2'b11;

  typedef enum logic [1:0] {
    THR_SEL_GREEN = 2'b00,
    THR_SEL_RED   = 2'b01,
    THR_SEL_BLUE  = 2'b10,
    THR_SEL_NONE  = 2'b11
  } thr_sel_e;

  localparam logic signed [HMS_THR_W-1:0] THR_R_DEF_C = 25'sh01E43DA;
  localparam logic signed [HMS_THR_W-1:0] THR_G_DEF_C = 25'sh00143DA;
  localparam logic signed [HMS_THR_W-1:0] THR_B_DEF_C = 25'sh0000000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Highest request bit wins: red > green > blue > pass-through.
  function automatic mode_t req_to_mode(input logic [3:0] edges);
    mode_t m;
    if (edges[3]) begin
      m = MODE_RED;
    end else if (edges[2]) begin
      m = MODE_GREEN;
    end else if (edges[1]) begin
      m = MODE_BLUE;
    end else begin
      m = MODE_PASS;
    end
    return m;
  endfunction

  function automatic mode_t mode_next(input mode_t m);
    mode_t n;
    case (m)
      MODE_RED:   n = MODE_GREEN;
      MODE_GREEN: n = MODE_BLUE;
      MODE_BLUE:  n = MODE_PASS;
      MODE_PASS:  n = MODE_RED;
      default:    n = MODE_PASS;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/highlight_mode_sched_if.sv
// Bundle between the switch/button front end (master) and the scheduler (slave).
interface highlight_mode_sched_if #(
  parameter int THR_W = 25
);
  logic [3:0]              req;
  logic                    vsync;
  logic                    auto_en;
  logic                    thr_wr;
  logic [1:0]              thr_sel;
  logic signed [THR_W-1:0] thr_data;
  logic [1:0]              mode;
  logic signed [THR_W-1:0] thr_r;
  logic signed [THR_W-1:0] thr_g;
  logic signed [THR_W-1:0] thr_b;
  logic                    pending;
  logic [15:0]             frame_cnt;

  modport master (
    output req, vsync, auto_en, thr_wr, thr_sel, thr_data,
    input  mode, thr_r, thr_g, thr_b, pending, frame_cnt
  );

  modport slave (
    input  req, vsync, auto_en, thr_wr, thr_sel, thr_data,
    output mode, thr_r, thr_g, thr_b, pending, frame_cnt
  );
endinterface

// File: rtl/highlight_mode_sched_edge_pulse.sv
// Parameterised rising-edge detector: one-cycle pulse where the input goes 0 -> 1.
module highlight_mode_sched_edge_pulse #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_q;

  // Delayed copy of the input for edge comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= {W{1'b0}};
    end else begin
      r_q <= i_d;
    end
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/highlight_mode_sched.sv
// Frame-synchronous highlight mode/threshold scheduler; changes commit only at frame start.
// Optional auto-cycle of the mode every AUTO_FRAMES frames when built with AUTO_CYCLE_EN.
module highlight_mode_sched
  import highlight_mode_sched_pkg::*;
#(
  parameter int                      THR_W       = HMS_THR_W,
  parameter logic signed [THR_W-1:0] THR_R_DEF   = THR_R_DEF_C,
  parameter logic signed [THR_W-1:0] THR_G_DEF   = THR_G_DEF_C,
  parameter logic signed [THR_W-1:0] THR_B_DEF   = THR_B_DEF_C,
  parameter int                      AUTO_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  highlight_mode_sched_if.slave s_bus
);

  logic [3:0]              w_req_edge;
  logic [0:0]              w_vs_edge;
  logic                    w_frame_start;
  logic                    w_any_req;
  logic                    w_thr_wr_ok;
  logic                    w_manual;
  logic                    w_auto_step;
  mode_t                   w_req_mode;
  mode_t                   w_mode_nxt;
  state_e                  r_state;
  state_e                  w_state_nxt;
  logic                    w_pending;
  mode_t                   r_mode;
  mode_t                   r_pmode;
  logic                    r_pmode_vld;
  logic signed [THR_W-1:0] r_sh_r;
  logic signed [THR_W-1:0] r_sh_g;
  logic signed [THR_W-1:0] r_sh_b;
  logic signed [THR_W-1:0] r_thr_r;
  logic signed [THR_W-1:0] r_thr_g;
  logic signed [THR_W-1:0] r_thr_b;
  logic [15:0]             r_frame_cnt;

  highlight_mode_sched_edge_pulse #(.W(4)) u_req_edge (
    .clk    (clk),
    .rst    (rst),
    .i_d    (s_bus.req),
    .o_rise (w_req_edge)
  );

  highlight_mode_sched_edge_pulse #(.W(1)) u_vsync_edge (
    .clk    (clk),
    .rst    (rst),
    .i_d    (s_bus.vsync),
    .o_rise (w_vs_edge)
  );

  assign w_frame_start = w_vs_edge[0];
  assign w_any_req     = |w_req_edge;
  assign w_req_mode    = req_to_mode(w_req_edge);
  assign w_thr_wr_ok   = s_bus.thr_wr && (thr_sel_e'(s_bus.thr_sel) != THR_SEL_NONE);
  assign w_manual      = w_any_req || r_pmode_vld;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A shadow write coinciding with frame start stays pending for the next frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_frame_start) begin
          w_state_nxt = w_thr_wr_ok ? ST_PEND : ST_IDLE;
        end else if (w_any_req || w_thr_wr_ok) begin
          w_state_nxt = ST_PEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (w_frame_start) begin
          w_state_nxt = w_thr_wr_ok ? ST_PEND : ST_IDLE;
        end else begin
          w_state_nxt = ST_PEND;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    w_pending = 1'b0;
    case (r_state)
      ST_IDLE: w_pending = 1'b0;
      ST_PEND: w_pending = 1'b1;
      default: w_pending = 1'b0;
    endcase
  end

  // Pending mode: last request before frame start wins; edges at frame start bypass it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pmode     <= MODE_PASS;
      r_pmode_vld <= 1'b0;
    end else if (w_frame_start) begin
      r_pmode_vld <= 1'b0;
    end else if (w_any_req) begin
      r_pmode     <= w_req_mode;
      r_pmode_vld <= 1'b1;
    end else begin
      r_pmode_vld <= r_pmode_vld;
    end
  end

  // Threshold shadows; select 11 is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_r <= THR_R_DEF;
      r_sh_g <= THR_G_DEF;
      r_sh_b <= THR_B_DEF;
    end else if (s_bus.thr_wr) begin
      case (thr_sel_e'(s_bus.thr_sel))
        THR_SEL_GREEN: r_sh_g <= s_bus.thr_data;
        THR_SEL_RED:   r_sh_r <= s_bus.thr_data;
        THR_SEL_BLUE:  r_sh_b <= s_bus.thr_data;
        default:       r_sh_r <= r_sh_r;
      endcase
    end else begin
      r_sh_r <= r_sh_r;
    end
  end

`ifdef AUTO_CYCLE_EN
  localparam logic [15:0] AUTO_LAST = 16'(AUTO_FRAMES - 1);

  logic [15:0] r_auto_cnt;
  logic [15:0] w_auto_cnt_nxt;

  // A manual commit at the same boundary beats the auto step and restarts the count.
  always_comb begin
    w_auto_cnt_nxt = r_auto_cnt;
    w_auto_step    = 1'b0;
    if (!s_bus.auto_en) begin
      w_auto_cnt_nxt = 16'd0;
    end else if (w_frame_start && w_manual) begin
      w_auto_cnt_nxt = 16'd0;
    end else if (w_frame_start && (r_auto_cnt >= AUTO_LAST)) begin
      w_auto_cnt_nxt = 16'd0;
      w_auto_step    = 1'b1;
    end else if (w_frame_start) begin
      w_auto_cnt_nxt = r_auto_cnt + 16'd1;
    end else begin
      w_auto_cnt_nxt = r_auto_cnt;
    end
  end

  // Auto-cycle frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_auto_cnt <= 16'd0;
    end else begin
      r_auto_cnt <= w_auto_cnt_nxt;
    end
  end
`else
  logic w_auto_unused;
  assign w_auto_unused = s_bus.auto_en;
  assign w_auto_step   = 1'b0;
`endif

  // Mode selection at frame start.
  always_comb begin
    w_mode_nxt = r_mode;
    if (w_frame_start) begin
      if (w_any_req) begin
        w_mode_nxt = w_req_mode;
      end else if (r_pmode_vld) begin
        w_mode_nxt = r_pmode;
      end else if (w_auto_step) begin
        w_mode_nxt = mode_next(r_mode);
      end else begin
        w_mode_nxt = r_mode;
      end
    end else begin
      w_mode_nxt = r_mode;
    end
  end

  // Active values: updated only on frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= MODE_PASS;
      r_thr_r     <= THR_R_DEF;
      r_thr_g     <= THR_G_DEF;
      r_thr_b     <= THR_B_DEF;
      r_frame_cnt <= 16'd0;
    end else if (w_frame_start) begin
      r_mode      <= w_mode_nxt;
      r_thr_r     <= r_sh_r;
      r_thr_g     <= r_sh_g;
      r_thr_b     <= r_sh_b;
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end else begin
      r_mode      <= r_mode;
    end
  end

  assign s_bus.mode      = r_mode;
  assign s_bus.thr_r     = r_thr_r;
  assign s_bus.thr_g     = r_thr_g;
  assign s_bus.thr_b     = r_thr_b;
  assign s_bus.pending   = w_pending;
  assign s_bus.frame_cnt = r_frame_cnt;

endmodule
